// File: rtl/mux4to1.sv
// -----------------------------------------------------------------------------
// mux4to1
//
// Registered 4-to-1 word multiplexer for the NCO datapath. On each rising edge
// of clk the word chosen by the 2-bit select is captured into the output
// register. mux_out comes only from that register, so it is glitch-free and
// has no combinational path from any input.
//
// Parameters:
//   width    bit width of every data input and of the output (default 16)
//
// Ports:
//   clk      in   1       system clock, rising-edge active
//   reset    in   1       synchronous, active-high; clears mux_out to 0
//   s        in   [2:1]   select, s[2] = MSB, s[1] = LSB
//   in1      in   width   selected when s = 2'b00
//   in2      in   width   selected when s = 2'b01
//   in3      in   width   selected when s = 2'b10
//   in4      in   width   selected when s = 2'b11
//   mux_out  out  width   registered selected word, 1-cycle latency
//
// Handshake: none. The register loads every cycle while reset is low; there
// is no enable and no valid/ready pairing.
// -----------------------------------------------------------------------------
module mux4to1 #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:1]       s,
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in2,
  input  logic [width-1:0] in3,
  input  logic [width-1:0] in4,
  output logic [width-1:0] mux_out
);

  logic [width-1:0] r_mux_out;
  logic [width-1:0] w_next;

  // Select decode. The default branch is reached only when s is X/Z in
  // simulation; it holds the current register value so an unknown select
  // never corrupts the output. All four codes are real selections in
  // hardware, so the default collapses away in synthesis.
  always_comb begin
    w_next = r_mux_out;
    case (s)
      2'b00:   w_next = in1;
      2'b01:   w_next = in2;
      2'b10:   w_next = in3;
      2'b11:   w_next = in4;
      default: w_next = r_mux_out;
    endcase
  end

  // Output register: reset takes priority over the selected data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mux_out <= '0;
    end else begin
      r_mux_out <= w_next;
    end
  end

  assign mux_out = r_mux_out;

endmodule

// File: tb/tb_mux4to1.sv
// -----------------------------------------------------------------------------
// tb_mux4to1
//
// Directed bench for mux4to1 (width = 16). Inputs are driven with blocking
// assignments away from the rising edge; mux_out is sampled 1 time unit after
// each rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mux4to1;

  localparam int W = 16;

  // clock / reset
  logic         clk;
  logic         reset;
  logic [2:1]   s;
  logic [W-1:0] in1, in2, in3, in4;
  logic [W-1:0] mux_out;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux4to1 #(.width(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .s       (s),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .in4     (in4),
    .mux_out (mux_out)
  );

  // driver: advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (mux_out === exp) else begin
      errors++;
      $error("FAIL %s: mux_out=%h expected=%h", tag, mux_out, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    s      = 2'b00;
    in1    = 16'h0000;
    in2    = 16'h0001;
    in3    = 16'h0002;
    in4    = 16'h0003;

    // reset held for two edges
    tick();
    check("reset_edge1", 16'h0000);
    tick();
    check("reset_edge2", 16'h0000);

    // first edge after reset release loads in1
    reset = 1'b0;
    tick();
    check("post_reset_in1", 16'h0000);

    // per-select routing
    s = 2'b01; tick(); check("route_01", 16'h0001);
    s = 2'b10; tick(); check("route_10", 16'h0002);
    s = 2'b11; tick(); check("route_11", 16'h0003);
    s = 2'b00; tick(); check("route_00", 16'h0000);

    // data tracking on the selected input
    s = 2'b00; in1 = 16'h8000; tick(); check("track_in1", 16'h8000);
    s = 2'b01; in2 = 16'hC000; tick(); check("track_in2", 16'hC000);
    s = 2'b10; in3 = 16'hE000; tick(); check("track_in3", 16'hE000);
    s = 2'b11; in4 = 16'hF000; tick(); check("track_in4", 16'hF000);

    // isolation: unselected inputs toggle, output must stay at in3
    s = 2'b10;
    in3 = 16'hE000;
    for (int i = 0; i < 4; i++) begin
      in1 = (i % 2 == 0) ? 16'hFFFF : 16'h5555;
      in2 = (i % 2 == 0) ? 16'h5555 : 16'hFFFF;
      in4 = (i % 2 == 0) ? 16'hFFFF : 16'h5555;
      tick();
      check("isolation", 16'hE000);
    end

    // reset mid-operation, with a nonzero selected word present
    s = 2'b11; in4 = 16'hF000;
    tick(); check("pre_reset_f000", 16'hF000);
    reset = 1'b1;
    tick(); check("mid_reset_clear", 16'h0000);
    reset = 1'b0;
    tick(); check("post_mid_reset", 16'hF000);

    // latency: change s just after an edge; output holds until next edge
    s = 2'b00; in1 = 16'h1234;
    tick(); check("lat_setup", 16'h1234);
    s = 2'b11;
    #2;
    check("lat_hold", 16'h1234);
    tick(); check("lat_update", 16'hF000);

    // simultaneous change of s and the newly selected input
    s = 2'b01; in2 = 16'hA5A5;
    tick(); check("simul_change", 16'hA5A5);

    // bit-for-bit pass-through of patterns on every bit
    s = 2'b10; in3 = 16'hFFFF; tick(); check("all_ones", 16'hFFFF);
    in3 = 16'h0001;            tick(); check("lsb_only", 16'h0001);
    s = 2'b00; in1 = 16'h8001; tick(); check("msb_lsb", 16'h8001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
